// File: rtl/fp_pkg.sv
// Shared types and constants for the IEEE-754 single-precision multiply sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_pkg;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   // Bit positions inside the 5-bit special-case flag word
   localparam int FLG_ZERO = 0;
   localparam int FLG_INF  = 1;
   localparam int FLG_NAN  = 2;
   localparam int FLG_OVF  = 3;
   localparam int FLG_UNF  = 4;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      MULT,
      NORM,
      ROUND,
      DONE
   } state_t;

   function automatic logic is_nan(input logic [7:0] e, input logic [22:0] f);
      return (e == 8'hFF) && (f != 23'd0);
   endfunction

   function automatic logic is_inf(input logic [7:0] e, input logic [22:0] f);
      return (e == 8'hFF) && (f == 23'd0);
   endfunction

endpackage

// File: rtl/fp_mant_mult_serial.sv
// Serial shift-add significand multiplier, one multiplier bit per cycle.
// Latency: done pulses MANT_W cycles after the cycle start is sampled; prod valid with done.
// Backpressure: none; a start while running restarts the multiply.
module fp_mant_mult_serial #(
   parameter int MANT_W = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [MANT_W-1:0]     mant_a,
   input  logic [MANT_W-1:0]     mant_b,
   output logic [2*MANT_W-1:0]   prod,
   output logic                  done
);

   localparam int CW = $clog2(MANT_W);

   logic [MANT_W-1:0] ma_q;
   logic [MANT_W-1:0] mb_q;
   logic [CW-1:0]     cnt;
   logic              running;

   // Bit 0 is folded into the start cycle so the full product lands after MANT_W edges
   always_ff @(posedge clk) begin
      if (!reset) begin
         ma_q    <= '0;
         mb_q    <= '0;
         cnt     <= '0;
         running <= 1'b0;
         prod    <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            ma_q    <= mant_a;
            mb_q    <= mant_b;
            prod    <= mant_b[0] ? {{MANT_W{1'b0}}, mant_a} : '0;
            cnt     <= CW'(1);
            running <= 1'b1;
         end else if (running) begin
            if (mb_q[cnt])
               prod <= prod + ({{MANT_W{1'b0}}, ma_q} << cnt);
            cnt <= cnt + CW'(1);
            if (cnt == CW'(MANT_W-1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fp_mult_sequencer.sv
// IEEE-754 single multiply: captures operands on inputdata_ready rising edge, returns dataR + flags.
// Latency: done 2 cycles after start for special operands, 2+MANT_W+2 cycles otherwise.
// Backpressure: none; rising edges of inputdata_ready while busy are dropped.
module fp_mult_sequencer
   import fp_pkg::*;
#(
   parameter int          MANT_W   = 24,
   parameter int          EXP_BIAS = 127,
   parameter logic [31:0] QNAN     = fp_pkg::QNAN
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inputdata_ready,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic [31:0] dataR,
   output logic [4:0]  casesspecialm,
   output logic        busy,
   output logic        done
);

   localparam int PW = 2*MANT_W;

   state_t state, next_state;

   logic              rdy_q;
   logic              start;
   logic              sign_q;
   logic [7:0]        ea_q, eb_q;
   logic [MANT_W-1:0] ma_q, mb_q;
   logic signed [9:0] exp_q;
   logic [MANT_W-1:0] mant_q;
   logic              guard_q, sticky_q;

   logic              mult_start, mult_done;
   logic [PW-1:0]     mult_prod;

   logic              spec_hit;
   logic [31:0]       spec_res;
   logic [4:0]        spec_flg;

   logic [PW-1:0]     p_adj;
   logic signed [9:0] norm_exp;

   logic [MANT_W:0]   rnd_sum;
   logic [MANT_W-1:0] rnd_mant;
   logic signed [9:0] rnd_exp;
   logic [31:0]       rnd_res;
   logic [4:0]        rnd_flg;

   assign start = inputdata_ready & ~rdy_q & (state == IDLE);

   fp_mant_mult_serial #(.MANT_W(MANT_W)) u_mant_mult (
      .clk    (clk),
      .reset  (reset),
      .start  (mult_start),
      .mant_a (ma_q),
      .mant_b (mb_q),
      .prod   (mult_prod),
      .done   (mult_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode, multiplier kick-off and status outputs
   always_comb begin
      next_state = state;
      mult_start = 1'b0;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE:  if (start) next_state = CHECK;
         CHECK: begin
            if (spec_hit) begin
               next_state = DONE;
            end else begin
               mult_start = 1'b1;
               next_state = MULT;
            end
         end
         MULT:  if (mult_done) next_state = NORM;
         NORM:  next_state = ROUND;
         ROUND: next_state = DONE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Special-operand classification in priority order: NaN / inf*0, inf, zero or denormal
   always_comb begin
      logic nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
      nan_a    = is_nan(ea_q, ma_q[22:0]);
      nan_b    = is_nan(eb_q, mb_q[22:0]);
      inf_a    = is_inf(ea_q, ma_q[22:0]);
      inf_b    = is_inf(eb_q, mb_q[22:0]);
      zer_a    = (ea_q == 8'd0);
      zer_b    = (eb_q == 8'd0);
      spec_hit = 1'b1;
      spec_res = '0;
      spec_flg = '0;
      if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) begin
         spec_res          = QNAN;
         spec_flg[FLG_NAN] = 1'b1;
      end else if (inf_a || inf_b) begin
         spec_res           = {sign_q, POS_INF[30:0]};
         spec_flg[FLG_INF]  = 1'b1;
      end else if (zer_a || zer_b) begin
         spec_res           = {sign_q, 31'd0};
         spec_flg[FLG_ZERO] = 1'b1;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Normalise the raw product to 1.xxx, folding the dropped bit into sticky
   always_comb begin
      p_adj    = mult_prod;
      norm_exp = exp_q;
      if (mult_prod[PW-1]) begin
         p_adj    = {1'b0, mult_prod[PW-1:1]};
         p_adj[0] = mult_prod[1] | mult_prod[0];
         norm_exp = exp_q + 10'sd1;
      end
   end

   // Round to nearest even, renormalise on carry-out, then clamp to inf or flush to zero
   always_comb begin
      rnd_sum  = {1'b0, mant_q} + {{MANT_W{1'b0}}, guard_q & (sticky_q | mant_q[0])};
      rnd_mant = rnd_sum[MANT_W-1:0];
      rnd_exp  = exp_q;
      if (rnd_sum[MANT_W]) begin
         rnd_mant = rnd_sum[MANT_W:1];
         rnd_exp  = exp_q + 10'sd1;
      end
      rnd_flg = '0;
      if (rnd_exp >= 10'sd255) begin
         rnd_res          = {sign_q, POS_INF[30:0]};
         rnd_flg[FLG_OVF] = 1'b1;
         rnd_flg[FLG_INF] = 1'b1;
      end else if (rnd_exp <= 10'sd0) begin
         rnd_res           = {sign_q, 31'd0};
         rnd_flg[FLG_UNF]  = 1'b1;
         rnd_flg[FLG_ZERO] = 1'b1;
      end else begin
         rnd_res = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
      end
   end

   // Operand capture, exponent/mantissa pipeline and result registers (updated only entering DONE)
   always_ff @(posedge clk) begin
      if (!reset) begin
         rdy_q         <= 1'b0;
         sign_q        <= 1'b0;
         ea_q          <= '0;
         eb_q          <= '0;
         ma_q          <= '0;
         mb_q          <= '0;
         exp_q         <= '0;
         mant_q        <= '0;
         guard_q       <= 1'b0;
         sticky_q      <= 1'b0;
         dataR         <= '0;
         casesspecialm <= '0;
      end else begin
         rdy_q <= inputdata_ready;
         case (state)
            IDLE: begin
               if (start) begin
                  sign_q <= dataA[31] ^ dataB[31];
                  ea_q   <= dataA[30:23];
                  eb_q   <= dataB[30:23];
                  ma_q   <= {|dataA[30:23], dataA[22:0]};
                  mb_q   <= {|dataB[30:23], dataB[22:0]};
               end
            end
            CHECK: begin
               exp_q <= {2'b00, ea_q} + {2'b00, eb_q} - 10'(EXP_BIAS);
               if (spec_hit) begin
                  dataR         <= spec_res;
                  casesspecialm <= spec_flg;
               end
            end
            NORM: begin
               mant_q   <= p_adj[PW-2 -: MANT_W];
               guard_q  <= p_adj[MANT_W-2];
               sticky_q <= |p_adj[MANT_W-3:0];
               exp_q    <= norm_exp;
            end
            ROUND: begin
               dataR         <= rnd_res;
               casesspecialm <= rnd_flg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Self-checking bench for fp_mult_sequencer: directed corner cases plus random operands vs a model.
// Latency: checks done timing relative to the start edge.
// Backpressure: exercises ignored restarts while busy and a long held inputdata_ready level.
module tb_fp_mult_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        inputdata_ready;
   logic [31:0] dataA, dataB;
   logic [31:0] dataR;
   logic [4:0]  casesspecialm;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fp_mult_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .inputdata_ready (inputdata_ready),
      .dataA           (dataA),
      .dataB           (dataB),
      .dataR           (dataR),
      .casesspecialm   (casesspecialm),
      .busy            (busy),
      .done            (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product of significands, rounded by remainder comparison
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, sh;
      longint unsigned fa, fb, p, q, rem, half;
      logic nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
      logic [31:0] r;
      logic [4:0] f;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = longint'(a[22:0]);
      fb = longint'(b[22:0]);
      nan_a = (ea == 255) && (fa != 0);
      nan_b = (eb == 255) && (fb != 0);
      inf_a = (ea == 255) && (fa == 0);
      inf_b = (eb == 255) && (fb == 0);
      zer_a = (ea == 0);
      zer_b = (eb == 0);
      f = 5'b0;
      if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) begin
         r = 32'h7FC00000; f = 5'b00100;
      end else if (inf_a || inf_b) begin
         r = {s, 8'hFF, 23'd0}; f = 5'b00010;
      end else if (zer_a || zer_b) begin
         r = {s, 31'd0}; f = 5'b00001;
      end else begin
         p = ((64'd1 << 23) | fa) * ((64'd1 << 23) | fb);
         e = ea + eb - 127;
         if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
         else sh = 23;
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
         if (e >= 255) begin
            r = {s, 8'hFF, 23'd0}; f = 5'b01010;
         end else if (e <= 0) begin
            r = {s, 31'd0}; f = 5'b10001;
         end else begin
            r = {s, e[7:0], q[22:0]};
         end
      end
      return {f, r};
   endfunction

   function automatic int exp_latency(input logic [4:0] f);
      return (f == 5'b00100 || f == 5'b00010 || f == 5'b00001) ? 2 : 28;
   endfunction

   // One full operation: k counts clock edges after the start edge E
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [36:0] m;
      int k, busy_n, lat;
      bit seen;
      m   = model(a, b);
      lat = exp_latency(m[36:32]);
      @(negedge clk);
      dataA = a; dataB = b; inputdata_ready = 1'b1;
      k = 0; busy_n = 0; seen = 1'b0;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
      chk({tag, "/done_seen"}, 32'(seen), 32'd1);
      chk({tag, "/latency"}, 32'(k), 32'(lat));
      chk({tag, "/busy_cycles"}, 32'(busy_n), 32'(lat));
      chk({tag, "/dataR"}, dataR, m[31:0]);
      chk({tag, "/flags"}, 32'(casesspecialm), 32'(m[36:32]));
      inputdata_ready = 1'b0;
      @(negedge clk);
      chk({tag, "/idle_after"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "/held"}, dataR, m[31:0]);
   endtask

   function automatic logic [31:0] rnd_fp();
      logic [7:0] e;
      logic [22:0] f;
      f = 23'($urandom);
      case ($urandom_range(0, 11))
         0:       begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = '0; end
         1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
         2, 3:    e = 8'($urandom_range(190, 254));
         4, 5:    e = 8'($urandom_range(1, 64));
         default: e = 8'($urandom_range(64, 190));
      endcase
      return {1'($urandom), e, f};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [36:0] m;
      int done_cnt, k;
      logic [31:0] r_seen;
      logic [4:0]  f_seen;

      reset = 1'b0; inputdata_ready = 1'b0; dataA = '0; dataB = '0;
      repeat (3) @(negedge clk);
      chk("rst/dataR", dataR, 32'd0);
      chk("rst/flags", 32'(casesspecialm), 32'd0);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/done", 32'(done), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op(32'h40000000, 32'h40400000, "2x3");
      run_op(32'h3F800001, 32'h3F800001, "near1_sq");
      run_op(32'h3FC00000, 32'h3FC00000, "1p5_sq");
      run_op(32'h7F800000, 32'h00000000, "inf_x_zero");
      run_op(32'h7F800000, 32'hC0000000, "inf_x_neg2");
      run_op(32'h7F000000, 32'h7F000000, "overflow");
      run_op(32'h00800000, 32'h00800000, "underflow");
      run_op(32'h7FC00001, 32'h3F800000, "nan_op");
      run_op(32'h80000001, 32'h40000000, "denorm_flush");
      run_op(32'hBF800000, 32'h3F800000, "neg_one");

      // Reset mid-multiply aborts with cleared outputs and no done
      @(negedge clk);
      dataA = 32'h40490FDB; dataB = 32'h402DF854; inputdata_ready = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      inputdata_ready = 1'b0;
      chk("abort/dataR", dataR, 32'd0);
      chk("abort/flags", 32'(casesspecialm), 32'd0);
      chk("abort/busy", 32'(busy), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort/no_done", 32'(done_cnt), 32'd0);
      run_op(32'h40490FDB, 32'h402DF854, "after_abort");

      // Held level gives one operation; a re-edge while busy is ignored
      m = model(32'h41200000, 32'hC0E00000);
      @(negedge clk);
      dataA = 32'h41200000; dataB = 32'hC0E00000; inputdata_ready = 1'b1;
      done_cnt = 0; r_seen = '0; f_seen = '0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 4) inputdata_ready = 1'b0;
         if (i == 5) inputdata_ready = 1'b1;
         if (done) begin
            done_cnt++;
            r_seen = dataR;
            f_seen = casesspecialm;
         end
      end
      inputdata_ready = 1'b0;
      chk("held/done_count", 32'(done_cnt), 32'd1);
      chk("held/dataR", r_seen, m[31:0]);
      chk("held/flags", 32'(f_seen), 32'(m[36:32]));
      @(negedge clk);

      for (k = 0; k < 40; k++) begin
         run_op(rnd_fp(), rnd_fp(), $sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
